// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO-to-stream drain block: default word width,
// default burst length and the output-buffer occupancy encoding.
package fifo_stream_pkg;

    localparam int WIDTH_DEFAULT     = 16;
    localparam int BURST_LEN_DEFAULT = 4;

    // Output-buffer occupancy; the encoding doubles as the numeric fill level.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry output buffer with occupancy state. Entry 0 is always the head;
// entry 1 is only meaningful when the buffer holds two words. A push and a pop
// in the same cycle keep the occupancy and advance the head.
module fifo_stream_skid
    import fifo_stream_pkg::*;
#(
    parameter int W = WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output occ_e         o_occ
);

    occ_e         r_occ;
    occ_e         w_occ_nxt;
    logic [W-1:0] r_ent0;
    logic [W-1:0] r_ent1;

    // Occupancy next-state: +1 on push only, -1 on pop only, hold otherwise.
    always_comb begin
        w_occ_nxt = r_occ;
        case ({i_push, i_pop})
            2'b10: begin
                case (r_occ)
                    EMPTY:   w_occ_nxt = ONE;
                    ONE:     w_occ_nxt = TWO;
                    default: w_occ_nxt = r_occ;
                endcase
            end
            2'b01: begin
                case (r_occ)
                    TWO:     w_occ_nxt = ONE;
                    ONE:     w_occ_nxt = EMPTY;
                    default: w_occ_nxt = r_occ;
                endcase
            end
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_occ <= EMPTY;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    // Entry storage: new words land at the tail, pops shift entry 1 to the head.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
        end else if (i_push && i_pop) begin
            if (r_occ == TWO) begin
                r_ent0 <= r_ent1;
                r_ent1 <= i_din;
            end else begin
                r_ent0 <= i_din;
            end
        end else if (i_push) begin
            if (r_occ == EMPTY) begin
                r_ent0 <= i_din;
            end else begin
                r_ent1 <= i_din;
            end
        end else if (i_pop) begin
            r_ent0 <= r_ent1;
        end
    end

    assign o_head = r_ent0;
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains an upstream synchronous FIFO (read data one cycle after the read
// strobe) into a valid/ready stream grouped in bursts of BURST_LEN beats.
// Handshake: a beat transfers on a rising clk edge where m_valid and m_ready
// are both high; once m_valid rises, m_data/m_last hold until that transfer.
// Optional build macro FIFO_STREAM_DRAIN_PARITY_EN adds m_parity, the XOR of
// m_data, stored alongside each buffered word.
module fifo_stream_drain
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_read,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
`ifdef FIFO_STREAM_DRAIN_PARITY_EN
    output logic             m_parity,
`endif
    output logic [1:0]       occ
);

    localparam int            BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);
`ifdef FIFO_STREAM_DRAIN_PARITY_EN
    localparam int            EW       = WIDTH + 1;
`else
    localparam int            EW       = WIDTH;
`endif

    logic          r_run;
    logic          r_pend;
    logic [BW-1:0] r_beat_idx;
    logic          w_pop;
    logic [2:0]    w_fill;
    occ_e          w_occ;
    logic [EW-1:0] w_din;
    logic [EW-1:0] w_head;

    assign m_valid = (w_occ != EMPTY);
    assign w_pop   = m_valid && m_ready;

    // Read issue: count buffered plus in-flight words so a read is only made
    // when its word is sure to find a free slot (or one freed by this pop).
    always_comb begin
        w_fill    = {1'b0, 2'(w_occ)} + {2'b00, r_pend};
        fifo_read = 1'b0;
        if (r_run && !fifo_empty) begin
            fifo_read = (w_fill < 3'd2) || ((w_fill == 3'd2) && w_pop);
        end
    end

    // Run flag: first posedge after reset release enables reads.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Pending flag: a read issued last cycle means fifo_data_out is valid now.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= fifo_read;
        end
    end

    // Beat counter within a burst; advances only on transfers, so idle gaps
    // never truncate a burst.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_beat_idx <= '0;
        end else if (w_pop) begin
            r_beat_idx <= (r_beat_idx == LAST_IDX) ? '0 : r_beat_idx + BW'(1);
        end
    end

`ifdef FIFO_STREAM_DRAIN_PARITY_EN
    assign w_din    = {^fifo_data_out, fifo_data_out};
    assign m_parity = w_head[WIDTH];
`else
    assign w_din    = fifo_data_out;
`endif

    fifo_stream_skid #(
        .W (EW)
    ) u_skid (
        .clk    (clk),
        .rst_   (rst_),
        .i_push (r_pend),
        .i_din  (w_din),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_occ  (w_occ)
    );

    assign m_data = w_head[WIDTH-1:0];
    assign m_last = (r_beat_idx == LAST_IDX) && m_valid;
    assign occ    = 2'(w_occ);

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain with a behavioural upstream FIFO.
module tb_fifo_stream_drain;

    localparam int WIDTH     = 16;
    localparam int BURST_LEN = 4;

    logic             clk = 1'b0;
    logic             rst_ = 1'b0;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data_out = '0;
    logic             fifo_read;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic [1:0]       occ;
`ifdef FIFO_STREAM_DRAIN_PARITY_EN
    logic             m_parity;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] fifo_mem [0:255];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    logic             rd_s = 1'b0;
    logic             rd_while_empty = 1'b0;
    logic [WIDTH-1:0] exp_q[$];
    int               beats_total = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    // Clock
    always #5 clk = ~clk;

    fifo_stream_drain #(
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_read     (fifo_read),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
`ifdef FIFO_STREAM_DRAIN_PARITY_EN
        .m_parity      (m_parity),
`endif
        .occ           (occ)
    );

    // Upstream FIFO: sample read strobe just before the edge, present data after it
    initial begin
        forever begin
            @(negedge clk);
            #4;
            rd_s = fifo_read;
            @(posedge clk);
            #1;
            if (rd_s) begin
                if (rd_ptr == wr_ptr) begin
                    rd_while_empty = 1'b1;
                end else begin
                    fifo_data_out = fifo_mem[rd_ptr[7:0]];
                    rd_ptr++;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_words(input int n, input logic [WIDTH-1:0] first);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[7:0]] = first + WIDTH'(i);
            exp_q.push_back(first + WIDTH'(i));
            wr_ptr++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_    = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        rst_        = 1'b1;
        beats_total = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] exp_d;
        logic             exp_l;
        bit               found;
        rst_    = 1'b0;
        m_ready = 1'b0;
        push_words(3, 16'h0001);
        tick();
        tick();
        n_tests++;
        if ({fifo_read, m_valid, m_last, occ, m_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: read=%b valid=%b last=%b occ=%0d data=%h, expected all 0",
                     fifo_read, m_valid, m_last, occ, m_data);
        end
        rst_    = 1'b1;
        m_ready = 1'b1;
        found   = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            tick();
            if (fifo_read === 1'b1) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_first_read: no fifo_read within 6 cycles of release, expected one");
        end
        tick();
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_latency_early: m_valid=%b one cycle after read, expected 0", m_valid);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_d = exp_q.pop_front();
            exp_l = (beats_total % BURST_LEN) == BURST_LEN - 1;
            n_tests++;
            if ({m_valid, m_data, m_last} !== {1'b1, exp_d, exp_l}) begin
                n_fail++;
                $display("FAIL reset_beat%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                         i, m_valid, m_data, m_last, exp_d, exp_l);
            end
            beats_total++;
            tick();
        end
        n_tests++;
        if (m_valid !== 1'b0 || occ !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_drained: valid=%b occ=%0d, expected 0 0", m_valid, occ);
        end
    endtask

    task automatic test_burst();
        logic [WIDTH-1:0] exp_d;
        logic             exp_l;
        do_reset();
        push_words(8, 16'h0010);
        m_ready = 1'b1;
        for (int c = 0; c < 8 && m_valid !== 1'b1; c++) tick();
        n_tests++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_start: m_valid=%b after 8 cycles, expected 1", m_valid);
        end
        for (int i = 0; i < 8; i++) begin
            exp_d = exp_q.pop_front();
            exp_l = (i == 3) || (i == 7);
            n_tests++;
            if ({m_valid, m_data, m_last} !== {1'b1, exp_d, exp_l}) begin
                n_fail++;
                $display("FAIL burst_beat%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                         i, m_valid, m_data, m_last, exp_d, exp_l);
            end
            beats_total++;
            tick();
        end
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_end: m_valid=%b after 8 beats, expected 0", m_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] exp_d;
        logic             exp_l;
        int               base;
        m_ready = 1'b0;
        base    = rd_ptr;
        push_words(6, 16'h0020);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (m_valid === 1'b1) begin
                n_tests++;
                if (m_data !== 16'h0020 || m_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold: data=%h last=%b, expected 0020 0", m_data, m_last);
                end
            end
        end
        n_tests++;
        if (occ !== 2'd2 || fifo_read !== 1'b0 || (rd_ptr - base) != 2) begin
            n_fail++;
            $display("FAIL bp_full: occ=%0d read=%b reads=%0d, expected 2 0 2",
                     occ, fifo_read, rd_ptr - base);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (m_valid === 1'b1) begin
                exp_d = exp_q.pop_front();
                exp_l = (beats_total % BURST_LEN) == BURST_LEN - 1;
                n_tests++;
                if (m_data !== exp_d || m_last !== exp_l) begin
                    n_fail++;
                    $display("FAIL bp_beat: data=%h last=%b, expected %h %b", m_data, m_last, exp_d, exp_l);
                end
                beats_total++;
            end
            tick();
        end
        n_tests++;
        if (exp_q.size() != 0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: %0d words missing, valid=%b, expected 0 0", exp_q.size(), m_valid);
        end
    endtask

    task automatic test_empty_drain();
        logic [WIDTH-1:0] exp_d;
        logic             exp_l;
        m_ready = 1'b0;
        push_words(2, 16'h0030);
        for (int c = 0; c < 10 && occ !== 2'd2; c++) tick();
        n_tests++;
        if (occ !== 2'd2) begin
            n_fail++;
            $display("FAIL empty_fill: occ=%0d, expected 2", occ);
        end
        for (int c = 0; c < 10; c++) begin
            m_ready = c[0];
            #1;
            n_tests++;
            if (fifo_read !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_no_read: fifo_read=%b at cycle %0d, expected 0", fifo_read, c);
            end
            if (m_valid === 1'b1 && m_ready) begin
                exp_d = exp_q.pop_front();
                exp_l = (beats_total % BURST_LEN) == BURST_LEN - 1;
                n_tests++;
                if (m_data !== exp_d || m_last !== exp_l) begin
                    n_fail++;
                    $display("FAIL empty_beat: data=%h last=%b, expected %h %b", m_data, m_last, exp_d, exp_l);
                end
                beats_total++;
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (occ !== 2'd0 || m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_stays: occ=%0d valid=%b, expected 0 0", occ, m_valid);
            end
            tick();
        end
        n_tests++;
        if (rd_while_empty !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL empty_guard: read_while_empty=%b missing=%0d, expected 0 0",
                     rd_while_empty, exp_q.size());
        end
    endtask

    task automatic test_idle_gap();
        logic [WIDTH-1:0] exp_d;
        logic             exp_l;
        do_reset();
        m_ready = 1'b1;
        for (int part = 0; part < 2; part++) begin
            push_words(2, (part == 0) ? 16'h0040 : 16'h0042);
            for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
                if (m_valid === 1'b1) begin
                    exp_d = exp_q.pop_front();
                    exp_l = (beats_total == 3);
                    n_tests++;
                    if (m_data !== exp_d || m_last !== exp_l) begin
                        n_fail++;
                        $display("FAIL gap_beat%0d: data=%h last=%b, expected %h %b",
                                 beats_total, m_data, m_last, exp_d, exp_l);
                    end
                    beats_total++;
                end
                tick();
            end
            n_tests++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL gap_drain: %0d words missing, expected 0", exp_q.size());
            end
            if (part == 0) begin
                for (int c = 0; c < 10; c++) begin
                    n_tests++;
                    if (m_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL gap_idle: m_valid=%b in gap cycle %0d, expected 0", m_valid, c);
                    end
                    tick();
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] exp_d;
        logic             exp_l;
        m_ready = 1'b0;
        push_words(6, 16'h0050);
        for (int c = 0; c < 10 && occ !== 2'd2; c++) tick();
        n_tests++;
        if (occ !== 2'd2 || m_data !== 16'h0050) begin
            n_fail++;
            $display("FAIL mid_fill: occ=%0d data=%h, expected 2 0050", occ, m_data);
        end
        void'(exp_q.pop_front());
        beats_total++;
        m_ready = 1'b1;
        @(posedge clk);
        #3;
        n_tests++;
        if (occ !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_inflight: occ=%0d with a read in flight, expected 1", occ);
        end
        rst_ = 1'b0;
        #1;
        n_tests++;
        if ({fifo_read, m_valid, m_last, occ, m_data} !== '0) begin
            n_fail++;
            $display("FAIL mid_async: read=%b valid=%b last=%b occ=%0d data=%h, expected all 0",
                     fifo_read, m_valid, m_last, occ, m_data);
        end
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        tick();
        tick();
        rst_        = 1'b1;
        beats_total = 0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (m_valid === 1'b1) begin
                exp_d = exp_q.pop_front();
                exp_l = (beats_total % BURST_LEN) == BURST_LEN - 1;
                n_tests++;
                if (m_data !== exp_d || m_last !== exp_l) begin
                    n_fail++;
                    $display("FAIL mid_beat: data=%h last=%b, expected %h %b", m_data, m_last, exp_d, exp_l);
                end
                beats_total++;
            end
            tick();
        end
        n_tests++;
        if (exp_q.size() != 0 || rd_while_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_drain: missing=%0d read_while_empty=%b, expected 0 0",
                     exp_q.size(), rd_while_empty);
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // Sequence
    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_empty_drain();
        test_idle_gap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
